// File: rtl/pc_run_pkg.sv
// ----------------------------------------------------------------------------
// pc_run_pkg
// Shared encodings for the PC run controller:
//   state_e  - controller state as seen on o_state
//   cmd_e    - host command opcodes on i_cmd_op
//   cause_e  - reason the core last stopped, as seen on o_halt_cause
//   EBREAK_ENC - RV32 EBREAK instruction word
// ----------------------------------------------------------------------------
package pc_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_HALT = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_HOST       = 3'd1,
        CAUSE_BREAKPOINT = 3'd2,
        CAUSE_EBREAK     = 3'd3,
        CAUSE_STEP_DONE  = 3'd4
    } cause_e;

    localparam logic [31:0] EBREAK_ENC = 32'h0010_0073;

endpackage

// File: rtl/pc_stop_detect.sv
// ----------------------------------------------------------------------------
// pc_stop_detect
// Combinational stop detection for the run controller. Flags a stop when the
// current PC hits the enabled breakpoint or the current instruction is EBREAK,
// unless the skip mask is set (used to step over the instruction that caused
// the previous stop).
// Ports:
//   i_pc, i_instr   current core PC and instruction word
//   i_bp_en         breakpoint enable
//   i_bp_addr       breakpoint address
//   i_skip          mask: forces o_stop low
//   o_stop          stop condition for this cycle
//   o_cause         EBREAK if the instruction matches, else BREAKPOINT
// ----------------------------------------------------------------------------
module pc_stop_detect
    import pc_run_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    input  logic            i_bp_en,
    input  logic [XLEN-1:0] i_bp_addr,
    input  logic            i_skip,
    output logic            o_stop,
    output logic [2:0]      o_cause
);

    logic w_bp_hit;
    logic w_ebreak_hit;

    assign w_bp_hit     = i_bp_en && (i_pc == i_bp_addr);
    assign w_ebreak_hit = (i_instr == XLEN'(EBREAK_ENC));
    assign o_stop       = !i_skip && (w_bp_hit || w_ebreak_hit);
    // EBREAK wins when both hit at once.
    assign o_cause      = w_ebreak_hit ? CAUSE_EBREAK : CAUSE_BREAKPOINT;

endmodule

// File: rtl/pc_run_controller.sv
// ----------------------------------------------------------------------------
// pc_run_controller
// Sequences a single-cycle RISC-V core through its PC/commit enable. Host
// commands RUN / STEP N / HALT move the controller between IDLE, RUN, STEP and
// HALTED; a breakpoint or EBREAK stops the core before that instruction
// commits. Retired instructions are counted and the stop reason is reported.
// Ports:
//   i_clk, i_reset          clock, async active-low reset
//   i_cmd_valid, i_cmd_op   host command strobe / opcode
//   i_step_count            STEP count (0 behaves as 1)
//   o_cmd_ready             high whenever out of reset
//   i_pc, i_instr           observed core PC and instruction
//   i_bp_en, i_bp_addr      PC breakpoint
//   o_PCen                  core PC/commit enable (combinational)
//   o_state, o_halt_cause   controller state and last stop reason
//   o_retired               committed instruction count (wraps)
// ----------------------------------------------------------------------------
module pc_run_controller
    import pc_run_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd_op,
    input  logic [STEP_W-1:0] i_step_count,
    output logic              o_cmd_ready,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_instr,
    input  logic              i_bp_en,
    input  logic [XLEN-1:0]   i_bp_addr,
    output logic              o_PCen,
    output logic [1:0]        o_state,
    output logic [2:0]        o_halt_cause,
    output logic [CNT_W-1:0]  o_retired
);

    state_e            r_state;
    cause_e            r_cause;
    logic [STEP_W-1:0] r_remaining;
    logic              r_skip;
    logic [CNT_W-1:0]  r_retired;

    logic              w_stop;
    logic [2:0]        w_stop_cause;
    logic              w_running;
    logic              w_pcen;
    cmd_e              w_cmd;

    pc_stop_detect #(
        .XLEN (XLEN)
    ) u_stop_detect (
        .i_pc      (i_pc),
        .i_instr   (i_instr),
        .i_bp_en   (i_bp_en),
        .i_bp_addr (i_bp_addr),
        .i_skip    (r_skip),
        .o_stop    (w_stop),
        .o_cause   (w_stop_cause)
    );

    assign w_cmd     = cmd_e'(i_cmd_op);
    assign w_running = (r_state == ST_RUN) || (r_state == ST_STEP);
    // A stopping instruction never gets its commit enable.
    assign w_pcen    = w_running && !w_stop;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_cause     <= CAUSE_NONE;
            r_remaining <= '0;
            r_skip      <= 1'b0;
            r_retired   <= '0;
        end else begin
            // Commit bookkeeping: one retire per enabled cycle; the skip mask
            // only covers the first instruction after a stop.
            if (w_pcen) begin
                r_retired <= r_retired + CNT_W'(1);
                r_skip    <= 1'b0;
            end

            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (i_cmd_valid && w_cmd == CMD_RUN) begin
                        r_state <= ST_RUN;
                        r_cause <= CAUSE_NONE;
                    end else if (i_cmd_valid && w_cmd == CMD_STEP) begin
                        r_state     <= ST_STEP;
                        r_cause     <= CAUSE_NONE;
                        r_remaining <= (i_step_count == '0) ? STEP_W'(1) : i_step_count;
                    end
                end
                default: begin
                    // stop implies !w_pcen, so the skip set here never
                    // collides with the clear above.
                    if (w_stop) begin
                        r_state <= ST_HALTED;
                        r_cause <= cause_e'(w_stop_cause);
                        r_skip  <= 1'b1;
                    end else if (i_cmd_valid && w_cmd == CMD_HALT) begin
                        r_state <= ST_HALTED;
                        r_cause <= CAUSE_HOST;
                    end else if (r_state == ST_STEP) begin
                        if (r_remaining == STEP_W'(1)) begin
                            r_state <= ST_HALTED;
                            r_cause <= CAUSE_STEP_DONE;
                        end else begin
                            r_remaining <= r_remaining - STEP_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign o_cmd_ready  = i_reset;
    assign o_PCen       = w_pcen;
    assign o_state      = r_state;
    assign o_halt_cause = r_cause;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_pc_run_controller.sv
module tb_pc_run_controller;

    localparam int XLEN   = 32;
    localparam int STEP_W = 16;
    localparam int CNT_W  = 8;           // narrow counter so wrap is reachable
    localparam int CMOD   = 1 << CNT_W;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] step_count;
    logic              cmd_ready;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic              bp_en;
    logic [XLEN-1:0]   bp_addr;
    logic              pcen;
    logic [1:0]        state;
    logic [2:0]        halt_cause;
    logic [CNT_W-1:0]  retired;

    pc_run_controller #(.XLEN(XLEN), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_cmd_valid  (cmd_valid),
        .i_cmd_op     (cmd_op),
        .i_step_count (step_count),
        .o_cmd_ready  (cmd_ready),
        .i_pc         (pc),
        .i_instr      (instr),
        .i_bp_en      (bp_en),
        .i_bp_addr    (bp_addr),
        .o_PCen       (pcen),
        .o_state      (state),
        .o_halt_cause (halt_cause),
        .o_retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             pcen;
        logic [1:0]       st;
        logic [2:0]       cause;
        logic [CNT_W-1:0] ret;
        logic             rdy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: mode 0 idle, 1 run, 2 step, 3 halted.
    int          m_mode  = 0;
    int          m_cause = 0;
    int          m_left  = 0;
    bit          m_skip  = 0;
    int          m_ret   = 0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] ebreak_pc = 32'hFFFF_FFF0;
    logic        m_bp_en = 0;
    logic [31:0] m_bp    = 32'h0;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        // Non-EBREAK words always end in 0x13, so they can never match.
        if (a == ebreak_pc) return EBRK;
        return 32'h0000_0013 | {4'h0, a[27:0] << 4} & 32'hFFFF_FF00 | 32'h13;
    endfunction

    // One clock cycle: drive inputs at the falling edge, queue what the
    // outputs must show during this cycle, then advance the model to what
    // the rising edge should produce.
    task automatic cyc(input bit v, input int op, input int cnt, input bit rn);
        exp_t e;
        bit   running, ebh, bph, stop, commit;
        @(negedge clk);
        rst_n      = rn;
        cmd_valid  = v;
        cmd_op     = 2'(op);
        step_count = STEP_W'(cnt);
        pc         = m_pc;
        instr      = instr_at(m_pc);
        bp_en      = m_bp_en;
        bp_addr    = m_bp;
        if (!rn) begin
            m_mode = 0; m_cause = 0; m_left = 0; m_skip = 0; m_ret = 0;
        end
        ebh     = (instr_at(m_pc) == EBRK);
        bph     = m_bp_en && (m_pc == m_bp);
        stop    = !m_skip && (ebh || bph);
        running = (m_mode == 1) || (m_mode == 2);
        commit  = rn && running && !stop;
        e.pcen  = commit;
        e.st    = 2'(m_mode);
        e.cause = 3'(m_cause);
        e.ret   = CNT_W'(m_ret);
        e.rdy   = rn;
        q.push_back(e);
        if (rn) begin
            if (commit) begin
                m_ret  = (m_ret + 1) % CMOD;
                m_skip = 0;
            end
            if (!running) begin
                if (v && op == 1) begin
                    m_mode = 1; m_cause = 0;
                end else if (v && op == 2) begin
                    m_mode = 2; m_cause = 0; m_left = (cnt == 0) ? 1 : cnt;
                end
            end else if (stop) begin
                m_mode = 3; m_cause = ebh ? 3 : 2; m_skip = 1;
            end else if (v && op == 3) begin
                m_mode = 3; m_cause = 1;
            end else if (m_mode == 2) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_mode = 3; m_cause = 4;
                end
            end
            if (commit) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
    endtask

    // Monitor: every cycle the outputs are valid; compare against the oldest
    // queued expectation.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (pcen !== e.pcen) begin
                errors++;
                $display("FAIL pcen t=%0t got=%b exp=%b", $time, pcen, e.pcen);
            end
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, e.st);
            end
            checks++;
            if (halt_cause !== e.cause) begin
                errors++;
                $display("FAIL halt_cause t=%0t got=%0d exp=%0d", $time, halt_cause, e.cause);
            end
            checks++;
            if (retired !== e.ret) begin
                errors++;
                $display("FAIL retired t=%0t got=%0d exp=%0d", $time, retired, e.ret);
            end
            checks++;
            if (cmd_ready !== e.rdy) begin
                errors++;
                $display("FAIL cmd_ready t=%0t got=%b exp=%b", $time, cmd_ready, e.rdy);
            end
        end
    end

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_op = 0; step_count = 0;
        pc = 0; instr = 0; bp_en = 0; bp_addr = 0;

        // Reset, then free run with no stop sources.
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        idle(2);
        cyc(1, 1, 0, 1);
        idle(10);
        cyc(1, 3, 0, 1);               // host halt, the cycle's instruction commits
        idle(2);
        cyc(1, 3, 0, 1);               // halt while halted: cause stays HOST
        idle(1);

        // STEP 3, then STEP 0 (acts as 1).
        cyc(1, 2, 3, 1);
        idle(5);
        cyc(1, 2, 0, 1);
        idle(3);

        // Breakpoint at 0x10, run into it, then step over it.
        m_pc = 32'h0; m_bp_en = 1; m_bp = 32'h10;
        cyc(1, 1, 0, 1);
        idle(7);
        cyc(1, 2, 1, 1);
        idle(3);
        m_bp_en = 0;

        // EBREAK two instructions ahead; rerun skips it once.
        ebreak_pc = m_pc + 32'd8;
        cyc(1, 1, 0, 1);
        idle(5);
        cyc(1, 1, 0, 1);
        idle(4);
        cyc(1, 3, 0, 1);
        idle(1);
        ebreak_pc = 32'hFFFF_FFF0;

        // Reset in the middle of STEP 8 with 5 left.
        cyc(1, 2, 8, 1);
        idle(3);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        idle(3);

        // Long run to wrap the narrow retire counter.
        cyc(1, 1, 0, 1);
        idle(CMOD + 10);
        cyc(1, 3, 0, 1);
        idle(1);

        // Random phase.
        for (int i = 0; i < 600; i++) begin
            int r;
            if (i % 40 == 0) begin
                m_bp_en   = ($urandom_range(0, 1) == 1);
                m_bp      = m_pc + 32'(4 * $urandom_range(0, 10));
                ebreak_pc = ($urandom_range(0, 2) == 0) ? m_pc + 32'(4 * $urandom_range(1, 12))
                                                        : 32'hFFFF_FFF0;
            end
            r = $urandom_range(0, 99);
            if (r < 1)       cyc(0, 0, 0, 0);
            else if (r < 25) cyc(1, $urandom_range(0, 3), $urandom_range(0, 6), 1);
            else             cyc($urandom_range(0, 1) == 1 && r < 30, 0, 0, 1);
        end

        idle(1);
        @(negedge clk); #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
